// File: rtl/flag_ring_anim.sv
// flag_ring_anim: dithered stripe-flag renderer with a bouncing ring emblem, 2-cycle pipeline.
module flag_ring_anim #(
   parameter int STRIPES  = 5,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int R_OUTER  = 101,
   parameter int R_INNER  = 64,
   parameter int SPEED    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        frame_start,
   input  logic        anim_en,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [11:0] wr_data,
   output logic [5:0]  color
);
   localparam int         BAND = V_ACTIVE / STRIPES;
   localparam logic [9:0] HA   = 10'(H_ACTIVE);
   localparam logic [9:0] VA   = 10'(V_ACTIVE);
   localparam logic [9:0] CY   = 10'(V_ACTIVE / 2);
   localparam logic [9:0] CX0  = 10'(H_ACTIVE / 2);
   localparam logic [9:0] LO   = 10'(R_OUTER);
   localparam logic [9:0] HI   = 10'(H_ACTIVE - 1 - R_OUTER);
   localparam logic [9:0] STEP = 10'(SPEED);
   localparam logic [20:0] RI2 = 21'(R_INNER * R_INNER);
   localparam logic [20:0] RO2 = 21'(R_OUTER * R_OUTER);

   logic [11:0] pal_q [8];
   logic [9:0]  cx_q, cx_d;
   logic        dir_q, dir_d;
   logic [2:0]  idx;
   logic [11:0] ent;
   logic [5:0]  stripe_d, stripe_q;
   logic        act_d, act_q;
   logic [9:0]  dx_d, dy_d, dx_q, dy_q;
   logic [20:0] r2;
   logic [5:0]  color_d, color_q;

   always_ff @(posedge clk)
      if (rst) for (int i = 0; i < 8; i++) pal_q[i] <= '0;
      else if (wr_en && int'(wr_addr) < STRIPES) pal_q[wr_addr] <= wr_data;

   // bounce: clamp to the bound and reverse when the step would reach or cross it
   logic adv, hit_hi, hit_lo;
   assign adv    = frame_start && anim_en;
   assign hit_hi = cx_q + STEP >= HI;
   assign hit_lo = cx_q <= LO + STEP;
   assign cx_d   = !adv ? cx_q : dir_q ? (hit_hi ? HI : cx_q + STEP) : (hit_lo ? LO : cx_q - STEP);
   assign dir_d  = !adv ? dir_q : dir_q ? !hit_hi : hit_lo;

   always_ff @(posedge clk)
      if (rst) begin
         cx_q  <= CX0;
         dir_q <= 1'b1;
      end else begin
         cx_q  <= cx_d;
         dir_q <= dir_d;
      end

   // comparator chain: last band absorbs remainder rows
   always_comb begin
      idx = '0;
      for (int k = 1; k < STRIPES; k++) if (pix_y >= 10'(k * BAND)) idx = 3'(k);
   end

   assign ent      = pal_q[idx];
   assign stripe_d = (pix_x[0] ^ pix_y[0]) ? ent[5:0] : ent[11:6];
   assign act_d    = pix_x < HA && pix_y < VA;
   assign dx_d     = pix_x >= cx_q ? pix_x - cx_q : cx_q - pix_x;
   assign dy_d     = pix_y >= CY ? pix_y - CY : CY - pix_y;

   always_ff @(posedge clk)
      if (rst) begin
         stripe_q <= '0;
         act_q    <= 1'b0;
         dx_q     <= '0;
         dy_q     <= '0;
      end else begin
         stripe_q <= stripe_d;
         act_q    <= act_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
      end

   assign r2      = 21'(dx_q) * 21'(dx_q) + 21'(dy_q) * 21'(dy_q);
   assign color_d = !act_q ? 6'd0 : r2 < RI2 ? 6'd0 : r2 < RO2 ? 6'h3f : stripe_q;

   always_ff @(posedge clk)
      if (rst) color_q <= '0;
      else color_q <= color_d;

   assign color = color_q;
endmodule

// File: tb/tb_flag_ring_anim.sv
// tb_flag_ring_anim: directed stimulus with a scoreboard queue checked two cycles after each pixel.
module tb_flag_ring_anim;
   logic        clk = 0, rst = 1, frame_start = 0, anim_en = 0, wr_en = 0;
   logic [9:0]  pix_x = 0, pix_y = 0;
   logic [2:0]  wr_addr = 0;
   logic [11:0] wr_data = 0;
   logic [5:0]  color;
   int checks = 0, fails = 0;
   bit pv = 0, v1 = 0, v2 = 0;

   typedef struct { string tag; logic [5:0] exp; } exp_t;
   exp_t q[$];

   flag_ring_anim dut (
      .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
      .anim_en(anim_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .color(color)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      v1 <= pv;
      v2 <= v1;
   end

   always @(negedge clk)
      if (v2) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty got=%b", color);
         end else begin
            e = q.pop_front();
            assert (color === e.exp) else begin
               fails++;
               $error("FAIL %s got=%b exp=%b", e.tag, color, e.exp);
            end
         end
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic [5:0] e);
      pix_x = 10'(x);
      pix_y = 10'(y);
      pv = 1;
      q.push_back('{tag, e});
      tick();
      pv = 0;
   endtask

   task automatic wr(input int a, input logic [11:0] d);
      wr_en = 1;
      wr_addr = 3'(a);
      wr_data = d;
      tick();
      wr_en = 0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1;
         tick();
         frame_start = 0;
         tick();
      end
   endtask

   task automatic flush();
      repeat (4) tick();
   endtask

   // centre located by the inner-radius edge on the centre row
   task automatic at_cx(input string tag, input int c);
      pix({tag, "_in"}, c + 63, 240, 6'h00);
      pix({tag, "_out"}, c + 64, 240, 6'h3f);
      pix({tag, "_lin"}, c - 63, 240, 6'h00);
      flush();
   endtask

   initial begin
      #300000;
      $error("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      tick();
      chk("reset_color", color, 6'h00);
      rst = 0;
      tick();
      chk("post_rst_1", color, 6'h00);
      tick();
      chk("post_rst_2", color, 6'h00);

      pix("centre_black", 320, 240, 6'h00);
      pix("annulus_white", 320, 160, 6'h3f);
      wr(0, 12'b010001_000001);
      pix("dither_a", 0, 0, 6'b010001);
      pix("dither_b", 1, 0, 6'b000001);
      pix("dither_b_y", 0, 1, 6'b000001);
      pix("dither_a_xy", 1, 1, 6'b010001);
      pix("offscreen_x", 640, 0, 6'h00);
      pix("offscreen_y", 0, 480, 6'h00);
      wr(4, 12'b000100_000100);
      pix("last_band", 0, 479, 6'b000100);
      pix("band4_start", 1, 384, 6'b000100);
      pix("band3_end", 0, 383, 6'h00);
      wr(6, 12'hfff);
      wr(5, 12'hfff);
      pix("ignored_wr_e0", 0, 0, 6'b010001);
      pix("ignored_wr_e4", 0, 479, 6'b000100);
      wr(2, 12'b110000_001100);
      pix("outer_in", 420, 240, 6'h3f);
      pix("outer_edge", 421, 240, 6'b001100);
      pix("outer_edge_a", 421, 241, 6'b110000);
      flush();
      at_cx("cx_reset", 320);

      anim_en = 1;
      pulses(100);
      at_cx("cx_420", 420);
      pulses(118);
      at_cx("cx_hi", 538);
      pulses(1);
      at_cx("cx_bounce", 537);
      anim_en = 0;
      pulses(5);
      at_cx("cx_frozen", 537);
      anim_en = 1;
      pulses(137);
      at_cx("cx_400", 400);

      rst = 1;
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("mid_rst_color", color, 6'h00);
      rst = 0;
      tick();
      chk("mid_rst_post", color, 6'h00);
      pix("rst_palette", 0, 0, 6'h00);
      pix("rst_palette4", 0, 479, 6'h00);
      flush();
      at_cx("cx_after_rst", 320);
      pulses(1);
      at_cx("dir_after_rst", 321);

      wr(1, 12'b000011_000011);
      wr_en = 1;
      wr_addr = 3'd1;
      wr_data = 12'b110011_110011;
      pix("same_cycle_old", 0, 100, 6'b000011);
      wr_en = 0;
      pix("next_cycle_new", 1, 100, 6'b110011);
      flush();

      checks++;
      assert (q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_left got=%0d exp=0", q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/flag_ring_anim.md
# flag_ring_anim

Parametrised stripe-flag renderer with a ring emblem that can move, for the VGA pride-flag demo. Each stripe has its own entry in a writable palette, and each entry holds two colours that are checkerboard-dithered. A ring emblem (black disc, white annulus) is drawn over the stripes. Its centre can bounce horizontally, advancing once per frame. The block sits between the VGA timing generator (pixel coordinates, frame pulse) and the 6-bit RRGGBB output mux, and produces a registered colour two cycles after each coordinate.

## Interface
Parameters:
- STRIPES, 5, number of equal-height horizontal bands (2..8)
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- R_OUTER, 101, outer ring radius in pixels
- R_INNER, 64, inner (disc) radius in pixels; must be < R_OUTER
- SPEED, 1, emblem x step per frame in pixels (1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- frame_start  in  1  one-cycle pulse once per frame, asserted during vertical blank
- anim_en  in  1  1 = emblem moves on each frame_start
- wr_en  in  1  palette write strobe
- wr_addr  in  3  palette entry (stripe index)
- wr_data  in  12  {colA[5:0], colB[5:0]}
- color  out  6  RRGGBB pixel colour, registered

## Operation
- Palette: STRIPES entries of 12 bits, all reset to 0.
  - A write with wr_en=1 stores wr_data at wr_addr on the clock edge.
  - Writes with wr_addr >= STRIPES are ignored.
- Stripe index:
  - BAND = V_ACTIVE/STRIPES (integer division). Index = pix_y/BAND, computed by a comparator chain with no divider.
  - The last stripe absorbs the remainder rows.
- Dither: sel = pix_x[0] ^ pix_y[0]. Stripe colour = sel ? colB : colA. If colA == colB the stripe is solid.
- Emblem geometry:
  - Centre is (cx, V_ACTIVE/2).
  - dx = |pix_x - cx| and dy = |pix_y - V_ACTIVE/2|, both 10 bits.
  - r2 = dx*dx + dy*dy, 21 bits, with no truncation.
- Emblem colour:
  - r2 < R_INNER² gives 6'b000000.
  - R_INNER² <= r2 < R_OUTER² gives 6'b111111.
  - The emblem has priority over the stripes.
- Outside the active area (pix_x >= H_ACTIVE or pix_y >= V_ACTIVE), color = 0.
- Animation state is cx (10 bits) and dir (1 = right). Reset values: cx = H_ACTIVE/2, dir = 1. Bounds are lo = R_OUTER and hi = H_ACTIVE-1-R_OUTER.
- On frame_start with anim_en = 1:
  - Moving right: if cx+SPEED >= hi, then cx <= hi and dir <= 0; otherwise cx <= cx+SPEED.
  - Moving left: mirrored against lo (cx-SPEED <= lo gives cx <= lo and dir <= 1).
- With anim_en = 0, cx and dir hold. Clearing anim_en mid-run freezes the emblem in place; it does not re-centre.

## Timing
- Two-stage pipeline.
  - Stage 1 registers: stripe colour, active flag, dx, dy.
  - Stage 2 registers: r2 compare and the final colour on color.
- Latency is exactly 2 clk from (pix_x, pix_y) to color, at a throughput of one pixel per clock.
- color resets to 0, and all pipeline registers reset to 0. For 2 cycles after rst deasserts, color = 0.
- A palette write takes effect for coordinates presented on the cycle after the write edge. A same-cycle read of that entry returns the old value.
- cx updates on the frame_start edge. Coordinates already in the pipeline use the new cx only if stage 1 samples after the edge.
  - Because frame_start is in blanking, every visible frame uses a single cx.
- rst and frame_start on the same cycle: reset wins, giving cx = H_ACTIVE/2 and dir = 1.
- Reset in mid-frame or mid-animation: palette, cx and dir all return to their reset values on that edge.

## Test plan
- Reset, then present (320,240) → color = 000000 two cycles later. Present (320,160) (r2 = 6400) → color = 111111.
- Write entry 0 = {010001,000001}. Then present (0,0) → 010001, and (1,0) → 000001. Present (640,0) → 000000.
- Write entry 4 = {000100,000100}. Then present (0,479) → 000100 (last band). Write to wr_addr = 6 → the palette is unchanged.
- anim_en = 1, default parameters: after 218 frame_start pulses cx = 538 and dir = 0; after one more pulse cx = 537. With anim_en = 0, further pulses leave cx unchanged.
- Assert rst mid-animation (cx = 400, dir = 0) → cx = 320, dir = 1, palette = 0, color = 0. Assert frame_start together with rst → cx stays 320.
- Issue wr_en for entry 1 on the same cycle as pixel (0,100) is presented → color reflects the old entry 1. Pixel (1,100) on the next cycle → reflects the new entry.
